// File: rtl/conv_pkg.sv
// Shared fixed-point constants for the tap summation datapath.
// Q8.8 operands, nine taps per requester, saturation bounds.
package conv_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;
  localparam int NUM_TAPS   = 9;
  localparam int GUARD_BITS = 4;

  localparam logic signed [31:0] SAT_MAX =  32'sh0000_7FFF;
  localparam logic signed [31:0] SAT_MIN = -32'sh0000_8000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a rotating pointer.
// Pointer moves past the winner only on an advance strobe.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Shared two-stage tap adder fed by round-robin requesters.
// Define ADDER_SAT_EN to saturate instead of wrapping the sum.
module adder_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  output logic [NUM_REQ-1:0]                o_req_ready,
  input  logic [NUM_REQ*9*DATA_WIDTH-1:0]   i_req_data,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     i_req_bias,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [DATA_WIDTH-1:0]             o_result,
  output logic [ID_WIDTH-1:0]               o_id,
  output logic                              o_busy
);

  import conv_pkg::*;

`ifdef ADDER_SAT_EN
  localparam int SW = DATA_WIDTH + GUARD_BITS;
`else
  localparam int SW = DATA_WIDTH;
`endif
  localparam int TW = NUM_TAPS * DATA_WIDTH;

  function automatic logic signed [SW-1:0] sx(
    input logic [DATA_WIDTH-1:0] v
  );
    return SW'($signed(v));
  endfunction

  logic [NUM_REQ-1:0]   grant;
  logic [ID_WIDTH-1:0]  gidx;
  logic                 adv2;
  logic                 load1;
  logic                 s1_valid;
  logic signed [SW-1:0] s1_i1;
  logic signed [SW-1:0] s1_i2;
  logic [ID_WIDTH-1:0]  s1_id;
  logic signed [SW-1:0] c_i1;
  logic signed [SW-1:0] c_i2;
  logic signed [SW-1:0] sum;
  logic [DATA_WIDTH-1:0] res;

  assign adv2   = !o_valid || i_ready;
  assign load1  = !s1_valid || adv2;
  assign o_busy = s1_valid || o_valid;
  assign o_req_ready = (load1 && !i_reset) ? grant : '0;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_WIDTH)
  ) u_arb (
    .clk   (i_clk),
    .rst   (i_reset),
    .req   (i_req_valid),
    .adv   (load1),
    .grant (grant),
    .idx   (gidx)
  );

  always_comb begin
    c_i1 = '0;
    for (int t = 0; t < NUM_TAPS - 1; t++) begin
      c_i1 = c_i1 + sx(
        i_req_data[int'(gidx)*TW + t*DATA_WIDTH +: DATA_WIDTH]);
    end
    c_i2 = sx(i_req_data[int'(gidx)*TW + (NUM_TAPS-1)*DATA_WIDTH
                         +: DATA_WIDTH])
         + sx(i_req_bias[int'(gidx)*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_comb begin
    sum = s1_i1 + s1_i2;
`ifdef ADDER_SAT_EN
    if (sum > $signed(SW'(SAT_MAX))) begin
      res = DATA_WIDTH'(SAT_MAX);
    end else if (sum < $signed(SW'(SAT_MIN))) begin
      res = DATA_WIDTH'(SAT_MIN);
    end else begin
      res = sum[DATA_WIDTH-1:0];
    end
`else
    res = sum;
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s1_i1    <= '0;
      s1_i2    <= '0;
      s1_id    <= '0;
    end else if (load1) begin
      s1_valid <= |i_req_valid;
      if (|i_req_valid) begin
        s1_i1 <= c_i1;
        s1_i2 <= c_i2;
        s1_id <= gidx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_id     <= '0;
    end else if (adv2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= res;
        o_id     <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: arbitration order,
// latency, backpressure hold, overflow and mid-run reset.
module tb_adder_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int NT = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR*NT*DW-1:0] req_data;
  logic [NR*DW-1:0]   req_bias;
  logic               o_valid;
  logic               i_ready;
  logic [DW-1:0]      o_result;
  logic [IW-1:0]      o_id;
  logic               o_busy;

  logic [DW-1:0] taps [NR][NT];
  logic [DW-1:0] bias [NR];

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   got_ids[$];
  int   got_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   mptr = 0;
  logic stall_q = 1'b0;
  logic [DW-1:0] res_q;
  logic [IW-1:0] id_q;
  logic [NR-1:0] g;
  int   gk;
  exp_t e;

  always #5 clk = ~clk;

  adder_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_data  (req_data),
    .i_req_bias  (req_bias),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_id        (o_id),
    .o_busy      (o_busy)
  );

  always_comb begin
    req_data = '0;
    req_bias = '0;
    for (int k = 0; k < NR; k++) begin
      for (int t = 0; t < NT; t++)
        req_data[(k*NT+t)*DW +: DW] = taps[k][t];
      req_bias[k*DW +: DW] = bias[k];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input int k);
    int s = 0;
    for (int t = 0; t < NT; t++)
      s += int'($signed(taps[k][t]));
    s += int'($signed(bias[k]));
`ifdef ADDER_SAT_EN
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
`endif
    return s[DW-1:0];
  endfunction

  // Reference model: rr pointer, scoreboard push/pop, hold check.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      mptr = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", o_valid, 1);
        check("hold_res", o_result, res_q);
        check("hold_id", o_id, id_q);
      end
      stall_q = o_valid && !i_ready;
      res_q = o_result;
      id_q = o_id;
      if (o_valid && i_ready) begin
        check("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res", o_result, e.res);
          check("id", o_id, e.id);
          got_ids.push_back(int'(o_id));
          got_cyc.push_back(cyc);
        end
      end
      if (req_ready != 0) begin
        g = '0;
        gk = 0;
        for (int i = 0; i < NR; i++) begin
          if (g == 0 && req_valid[(mptr+i)%NR]) begin
            gk = (mptr + i) % NR;
            g[gk] = 1'b1;
          end
        end
        check("grant", req_ready, g);
        if ((req_valid & req_ready) != 0) begin
          sb.push_back('{id: IW'(gk), res: model(gk)});
          mptr = (gk + 1) % NR;
        end
      end
    end
  end

  task automatic tick();
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    xfer_cnt += $countones(acc);
  endtask

  task automatic drain();
    for (int n = 0; n < 30; n++) begin
      if (sb.size() == 0 && !o_busy) break;
      @(posedge clk);
      #1;
    end
    check("drain", sb.size() == 0 && !o_busy, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] base,
                         input logic [DW-1:0] b);
    for (int t = 0; t < NT; t++)
      taps[k][t] = base + DW'(t * 3);
    bias[k] = b;
  endtask

  task automatic send_ovf(input logic [DW-1:0] tap,
                          input logic [DW-1:0] exp);
    for (int t = 0; t < NT; t++) taps[0][t] = tap;
    bias[0] = '0;
    req_valid = 4'b0001;
    tick();
    @(posedge clk);
    #1;
    check("ovf", o_result, exp);
    drain();
  endtask

  task automatic flush_reqs();
    for (int n = 0; n < 40 && req_valid != 0; n++) tick();
    check("reqs_done", req_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    i_ready = 1'b1;
    for (int k = 0; k < NR; k++) set_req(k, '0, '0);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ready", req_ready, 0);
    check("rst_result", o_result, 0);
    check("rst_id", o_id, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int t = 0; t < NT; t++) taps[0][t] = 16'h0100;
    bias[0] = 16'h0080;
    req_valid = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    tick();
    check("single_lat1", o_valid, 0);
    @(posedge clk);
    #1;
    check("single_lat2", o_valid, 1);
    check("single_res", o_result, 16'h0980);
    check("single_id", o_id, 0);
    drain();

`ifdef ADDER_SAT_EN
    send_ovf(16'h7000, 16'h7FFF);
    send_ovf(16'h9000, 16'h8000);
`else
    send_ovf(16'h7000, 16'hF000);
    send_ovf(16'h9000, 16'h1000);
`endif

    do_reset();
    got_ids.delete();
    got_cyc.delete();
    for (int k = 0; k < NR; k++)
      set_req(k, DW'(k * 16'h0100 + 16'h0010), DW'(k * 5));
    req_valid = 4'hF;
    flush_reqs();
    req_valid = 4'b0100;
    #1;
    check("rr_req2", req_ready, 4'b0100);
    tick();
    drain();
    check("cont_n", got_ids.size(), 5);
    if (got_ids.size() == 5) begin
      for (int i = 0; i < 4; i++) check("cont_order", got_ids[i], i);
      check("cont_b2b", got_cyc[3] - got_cyc[0], 3);
      check("cont_req2", got_ids[4], 2);
    end

    got_ids.delete();
    set_req(0, 16'hF800, 16'h0123);
    set_req(1, 16'h0A00, 16'hFF00);
    set_req(2, 16'h1234, 16'h0001);
    set_req(3, 16'hC000, 16'h4000);
    i_ready = 1'b0;
    req_valid = 4'hF;
    xfer_cnt = 0;
    repeat (5) tick();
    check("bp_xfers", xfer_cnt, 2);
    check("bp_valid", o_valid, 1);
    i_ready = 1'b1;
    flush_reqs();
    drain();
    check("bp_n", got_ids.size(), 4);

    i_ready = 1'b0;
    set_req(1, 16'h0300, 16'h0007);
    set_req(3, 16'hFF00, 16'h0100);
    req_valid = 4'hF;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid", o_valid, 0);
    check("mid_busy", o_busy, 0);
    check("mid_ready", req_ready, 0);
    check("mid_result", o_result, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'hF;
    #1;
    check("mid_first", req_ready, 4'b0001);
    i_ready = 1'b1;
    flush_reqs();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning operand/result width in Q8.8 fixed point.
REQ-002 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one summation pipeline.
REQ-003 SHALL have parameter ID_WIDTH, default 2, meaning the tag width, equal to clog2(NUM_REQ).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_req_valid, input, NUM_REQ bits: per-requester operand valid.
REQ-007 SHALL have port o_req_ready, output, NUM_REQ bits: per-requester accept.
REQ-008 SHALL have port i_req_data, input, NUM_REQ*9*DATA_WIDTH bits: nine signed taps per requester, flattened, tap 0 in the LSBs.
REQ-009 SHALL have port i_req_bias, input, NUM_REQ*DATA_WIDTH bits: signed bias per requester.
REQ-010 SHALL have port o_valid, output, 1 bit: result valid.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have port o_result, output, DATA_WIDTH bits: signed sum of the nine taps plus bias.
REQ-013 SHALL have port o_id, output, ID_WIDTH bits: index of the requester that produced o_result.
REQ-014 SHALL have port o_busy, output, 1 bit: high while any pipeline stage is occupied.

Function
REQ-015 SHALL perform a transfer on requester k when i_req_valid[k] and o_req_ready[k] are both high at a rising edge.
REQ-016 SHALL use round-robin arbitration: grant goes to the first valid requester at or after a pointer; after a transfer the pointer becomes (granted+1) mod NUM_REQ.
REQ-017 SHALL assert at most one o_req_ready bit per cycle, only for the granted requester, and only when stage 1 can load.
REQ-018 SHALL register in stage 1: inter1 = taps 0..7 summed, inter2 = tap 8 + bias, plus the id.
REQ-019 SHALL register in stage 2: o_result = inter1 + inter2, with the id on o_id.
REQ-020 SHALL give a latency of 2 cycles from transfer edge to o_valid high; unstalled throughput SHALL be 1 result per cycle.
REQ-021 SHALL let stage 2 advance when it is empty or i_ready is high, and stage 1 load when it is empty or advancing; o_req_ready MAY depend combinationally on i_ready.
REQ-022 SHALL hold o_valid, o_result and o_id stable while o_valid is high and i_ready is low, with no loss or duplication.
REQ-023 SHALL leave the pointer unchanged when no requester is valid; a requester's valid SHALL be kept until its transfer.

Reset
REQ-024 SHALL on i_reset, immediately and asynchronously: clear both stage-valid bits, o_valid=0, o_result=0, o_id=0, o_busy=0, o_req_ready=0, pointer=0.
REQ-025 SHALL discard in-flight results on reset mid-operation; no stale result SHALL appear after release.

Configuration
REQ-026 SHALL compute the sum at DATA_WIDTH+4 bits and saturate to [0x8000, 0x7FFF] when ADDER_SAT_EN is defined.
REQ-027 SHALL wrap the result modulo 2^DATA_WIDTH when ADDER_SAT_EN is undefined, bit-identical to the existing adder_tree.

Structure
REQ-028 SHALL place DATA_WIDTH, FRAC_BITS=8, NUM_TAPS=9 and the saturation limits in shared package conv_pkg.
REQ-029 SHALL implement arbitration in sub-module rr_arbiter (request vector, advance strobe -> one-hot grant, grant index); summation SHALL be inline.

Verification
REQ-030 SHALL cover single requester: req0 taps all 0x0100, bias 0x0080 -> o_result 0x0980, o_id 0, o_valid 2 cycles after transfer.
REQ-031 SHALL cover contention: all four requesters valid, i_ready=1 -> o_id 0,1,2,3 back-to-back; then only req2 valid -> granted the next cycle.
REQ-032 SHALL cover backpressure: i_ready low for 5 cycles with all requesters valid -> outputs stable, exactly 2 transfers, all results later delivered in order.
REQ-033 SHALL cover overflow: taps 0x7000, bias 0 -> 0xF000 without the macro, 0x7FFF with it; taps 0x9000 -> 0x1000 without, 0x8000 with.
REQ-034 SHALL cover reset mid-operation: i_reset with 2 results in flight -> o_valid and o_busy 0 with no clock edge, first grant after release goes to req0.
